// File: rtl/sw_us_mode_ctrl_pkg.sv
// Shared encodings for the stopwatch/ultrasonic mode controller.
// Also holds a helper that sizes the elapsed-ms counter.
package sw_us_mode_ctrl_pkg;

   typedef enum logic [1:0] {
      SW_STOP  = 2'd0,
      SW_RUN   = 2'd1,
      SW_CLEAR = 2'd2
   } sw_state_e;

   typedef enum logic [1:0] {
      US_IDLE = 2'd0,
      US_TRIG = 2'd1,
      US_WAIT = 2'd2,
      US_HOLD = 2'd3
   } us_state_e;

   localparam logic MODE_SW = 1'b0;
   localparam logic MODE_US = 1'b1;

   // The elapsed counter only needs to reach the period, never beyond it.
   function automatic int ms_cnt_width(input int period_ms);
      return (period_ms < 1) ? 1 : $clog2(period_ms + 1);
   endfunction

endpackage

// File: rtl/sw_us_mode_ctrl_ms_tick_gen.sv
// DIV-cycle prescaler with synchronous clear and a registered one-cycle tick.
// The tick is high in the cycle where the count sits at DIV-1.
module ms_tick_gen #(
   parameter int DIV = 100_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick_q;
   logic          tick_d;

   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (i_clr) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      tick_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign o_tick = tick_q;

endmodule

// File: rtl/sw_us_mode_ctrl.sv
// Mode/sequencing controller: stopwatch run/stop/clear FSM plus a periodic
// ultrasonic measurement scheduler with timeout, sharing the same buttons.
module sw_us_mode_ctrl
   import sw_us_mode_ctrl_pkg::*;
#(
   parameter int CLK_HZ        = 100_000_000,
   parameter int US_PERIOD_MS  = 100,
   parameter int US_TIMEOUT_MS = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic i_btn_run_stop,
   input  logic i_btn_clear,
   input  logic i_btn_run_md,
   input  logic i_us_done,
   output logic o_mode,
   output logic o_sw_run,
   output logic o_sw_clear,
   output logic o_us_start,
   output logic o_us_clear,
   output logic o_us_timeout
);

   localparam int DIV = CLK_HZ / 1000;
   localparam int MW  = ms_cnt_width(US_PERIOD_MS);
   localparam logic [MW-1:0] MS_PER = MW'(US_PERIOD_MS);
   localparam logic [MW-1:0] MS_TO  = MW'(US_TIMEOUT_MS);

   logic          mode_q, mode_d;
   logic          us_en_q, us_en_d;
   sw_state_e     sw_state_q, sw_state_d;
   us_state_e     us_state_q, us_state_d;
   logic [MW-1:0] ms_q, ms_d;
   logic          sw_run_q, sw_run_d;
   logic          sw_clear_q, sw_clear_d;
   logic          us_start_q, us_start_d;
   logic          us_clear_q, us_clear_d;
   logic          us_timeout_q, us_timeout_d;

   logic          sw_rs_s, sw_clr_s, us_rs_s, us_clr_s;
   logic          tick_s, tick_clr_s, timeout_s;
   logic [MW-1:0] ms_inc_s;

   ms_tick_gen #(.DIV(DIV)) u_tick (
      .clk    (clk),
      .reset  (reset),
      .i_clr  (tick_clr_s),
      .o_tick (tick_s)
   );

   // A mode-toggle cycle swallows any run_stop/clear pulse arriving with it.
   always_comb begin
      mode_d   = mode_q ^ i_btn_run_md;
      sw_rs_s  = !i_btn_run_md && (mode_q == MODE_SW) && i_btn_run_stop;
      sw_clr_s = !i_btn_run_md && (mode_q == MODE_SW) && i_btn_clear;
      us_rs_s  = !i_btn_run_md && (mode_q == MODE_US) && i_btn_run_stop;
      us_clr_s = !i_btn_run_md && (mode_q == MODE_US) && i_btn_clear;
      us_en_d  = us_en_q;
      if (i_btn_run_md && (mode_q == MODE_US)) begin
         us_en_d = 1'b0;
      end else if (us_rs_s) begin
         us_en_d = !us_en_q;
      end else begin
         us_en_d = us_en_q;
      end
   end

   always_comb begin
      sw_state_d = sw_state_q;
      case (sw_state_q)
         SW_STOP: begin
            if (sw_clr_s) begin
               sw_state_d = SW_CLEAR;
            end else if (sw_rs_s) begin
               sw_state_d = SW_RUN;
            end else begin
               sw_state_d = SW_STOP;
            end
         end
         SW_RUN: begin
            if (sw_rs_s) begin
               sw_state_d = SW_STOP;
            end else begin
               sw_state_d = SW_RUN;
            end
         end
         SW_CLEAR: sw_state_d = SW_STOP;
         default:  sw_state_d = SW_STOP;
      endcase
   end

   // The enable is looked at in its next-cycle form so a button acts in N+1.
   always_comb begin
      us_state_d = us_state_q;
      timeout_s  = 1'b0;
      if (!us_en_d) begin
         us_state_d = US_IDLE;
      end else begin
         case (us_state_q)
            US_IDLE: us_state_d = US_TRIG;
            US_TRIG: us_state_d = US_WAIT;
            US_WAIT: begin
               if (i_us_done) begin
                  us_state_d = US_HOLD;
               end else if (tick_s && (ms_inc_s == MS_TO)) begin
                  us_state_d = US_HOLD;
                  timeout_s  = 1'b1;
               end else begin
                  us_state_d = US_WAIT;
               end
            end
            US_HOLD: begin
               if (tick_s && (ms_inc_s == MS_PER)) begin
                  us_state_d = US_TRIG;
               end else begin
                  us_state_d = US_HOLD;
               end
            end
            default: us_state_d = US_IDLE;
         endcase
      end
   end

   // Clearing on entry to US_TRIG makes the trigger cycle count as elapsed
   // cycle zero, giving exact start-to-start and start-to-timeout spacing.
   always_comb begin
      tick_clr_s = (us_state_d == US_TRIG);
      ms_inc_s   = ms_q;
      if (tick_s && (ms_q != MS_PER)) begin
         ms_inc_s = ms_q + MW'(1);
      end else begin
         ms_inc_s = ms_q;
      end
      if (tick_clr_s) begin
         ms_d = '0;
      end else begin
         ms_d = ms_inc_s;
      end
      sw_run_d     = (sw_state_d == SW_RUN);
      sw_clear_d   = (sw_state_d == SW_CLEAR);
      us_start_d   = (us_state_d == US_TRIG);
      us_clear_d   = us_clr_s;
      us_timeout_d = timeout_s;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q       <= MODE_SW;
         us_en_q      <= 1'b0;
         sw_state_q   <= SW_STOP;
         us_state_q   <= US_IDLE;
         ms_q         <= '0;
         sw_run_q     <= 1'b0;
         sw_clear_q   <= 1'b0;
         us_start_q   <= 1'b0;
         us_clear_q   <= 1'b0;
         us_timeout_q <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         us_en_q      <= us_en_d;
         sw_state_q   <= sw_state_d;
         us_state_q   <= us_state_d;
         ms_q         <= ms_d;
         sw_run_q     <= sw_run_d;
         sw_clear_q   <= sw_clear_d;
         us_start_q   <= us_start_d;
         us_clear_q   <= us_clear_d;
         us_timeout_q <= us_timeout_d;
      end
   end

   assign o_mode       = mode_q;
   assign o_sw_run     = sw_run_q;
   assign o_sw_clear   = sw_clear_q;
   assign o_us_start   = us_start_q;
   assign o_us_clear   = us_clear_q;
   assign o_us_timeout = us_timeout_q;

endmodule

// File: tb/tb_sw_us_mode_ctrl.sv
// Bench for sw_us_mode_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a cycle-count based behavioural model.
module tb_sw_us_mode_ctrl;

   localparam int PER_CYC = 50;  // US_PERIOD_MS * DIV
   localparam int TO_CYC  = 30;  // US_TIMEOUT_MS * DIV

   logic clk, reset;
   logic i_btn_run_stop, i_btn_clear, i_btn_run_md, i_us_done;
   logic o_mode, o_sw_run, o_sw_clear, o_us_start, o_us_clear, o_us_timeout;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int run_hi = 0;

   // model state: measurement timing is kept as absolute cycle numbers
   logic m_mode, m_run, m_clr_out, m_en, m_got;
   int   m_st;
   logic e_swclr, e_start, e_usclr, e_to;

   sw_us_mode_ctrl #(
      .CLK_HZ        (10_000),
      .US_PERIOD_MS  (5),
      .US_TIMEOUT_MS (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_btn_run_stop (i_btn_run_stop),
      .i_btn_clear    (i_btn_clear),
      .i_btn_run_md   (i_btn_run_md),
      .i_us_done      (i_us_done),
      .o_mode         (o_mode),
      .o_sw_run       (o_sw_run),
      .o_sw_clear     (o_sw_clear),
      .o_us_start     (o_us_start),
      .o_us_clear     (o_us_clear),
      .o_us_timeout   (o_us_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic mdl_reset();
      m_mode = 1'b0; m_run = 1'b0; m_clr_out = 1'b0; m_en = 1'b0; m_got = 1'b0;
      m_st = -1;
      e_swclr = 1'b0; e_start = 1'b0; e_usclr = 1'b0; e_to = 1'b0;
   endtask

   task automatic step(input logic rs, input logic clr, input logic md, input logic done);
      logic en_chg;
      en_chg  = 1'b0;
      e_swclr = 1'b0; e_start = 1'b0; e_usclr = 1'b0; e_to = 1'b0;
      i_btn_run_stop = rs; i_btn_clear = clr; i_btn_run_md = md; i_us_done = done;
      if (md) begin
         if (m_mode) begin
            m_en = 1'b0;
            m_st = -1;
         end
         m_mode = !m_mode;
      end else if (!m_mode) begin
         if (!m_clr_out) begin
            if (!m_run && clr) e_swclr = 1'b1;
            else if (rs) m_run = !m_run;
         end
      end else begin
         e_usclr = clr;
         if (rs) begin
            en_chg = 1'b1;
            m_en   = !m_en;
            m_st   = -1;
            if (m_en) begin
               m_st    = cyc + 1;
               m_got   = 1'b0;
               e_start = 1'b1;
            end
         end
      end
      if (m_en && !en_chg && m_st >= 0) begin
         if (done && cyc > m_st && cyc < m_st + TO_CYC) m_got = 1'b1;
         if (cyc + 1 == m_st + TO_CYC && !m_got) e_to = 1'b1;
         if (cyc + 1 == m_st + PER_CYC) begin
            e_start = 1'b1;
            m_st    = cyc + 1;
            m_got   = 1'b0;
         end
      end
      m_clr_out = e_swclr;
      @(posedge clk);
      #1;
      chk("o_mode", o_mode, m_mode);
      chk("o_sw_run", o_sw_run, m_run);
      chk("o_sw_clear", o_sw_clear, e_swclr);
      chk("o_us_start", o_us_start, e_start);
      chk("o_us_clear", o_us_clear, e_usclr);
      chk("o_us_timeout", o_us_timeout, e_to);
      if (o_sw_run === 1'b1) run_hi++;
      cyc++;
      i_btn_run_stop = 1'b0; i_btn_clear = 1'b0; i_btn_run_md = 1'b0; i_us_done = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // dly > 0: answer each measurement dly cycles after its start
   task automatic run_us(input int n, input int dly);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b0, 1'b0, (dly > 0) && (m_st >= 0) && (cyc == m_st + dly));
   endtask

   initial begin
      reset = 1'b1;
      i_btn_run_stop = 1'b0; i_btn_clear = 1'b0; i_btn_run_md = 1'b0; i_us_done = 1'b0;
      mdl_reset();
      @(posedge clk);
      #1;
      chk("rst_mode", o_mode, 1'b0);
      chk("rst_sw_run", o_sw_run, 1'b0);
      chk("rst_us_start", o_us_start, 1'b0);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;

      // stopwatch run for 5 cycles, then clear
      run_hi = 0;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(4);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(3);
      checks++;
      assert (run_hi == 5) else begin
         errors++;
         $error("FAIL sw_run_len: observed %0d expected 5", run_hi);
      end

      // clear wins over run_stop; clear ignored while running
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(2);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);

      // stopwatch left running, ultrasonic periodic with answers at +12
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run_us(160, 12);

      // timeouts, then done exactly in the timeout decision cycle
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      run_us(110, 0);
      run_us(60, TO_CYC - 1);
      step(1'b0, 1'b1, 1'b0, 1'b0);

      // back to stopwatch mode during US_WAIT, then mode+run_stop together
      for (int k = 0; k < PER_CYC + 5 && cyc != m_st + 10; k++) idle(1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(60);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      idle(5);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(10);

      // async reset in US_WAIT with the stopwatch running
      #3 reset = 1'b1;
      #1;
      chk("arst_mode", o_mode, 1'b0);
      chk("arst_sw_run", o_sw_run, 1'b0);
      chk("arst_sw_clear", o_sw_clear, 1'b0);
      chk("arst_us_start", o_us_start, 1'b0);
      chk("arst_us_clear", o_us_clear, 1'b0);
      chk("arst_us_timeout", o_us_timeout, 1'b0);
      mdl_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      @(posedge clk);
      #1;
      idle(60);

      // random button and echo traffic
      for (int i = 0; i < 1500; i++)
         step($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 79) == 0, $urandom_range(0, 24) == 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sw_us_mode_ctrl.md
# sw_us_mode_ctrl

Mode and sequencing controller between the debounced button block and the stopwatch/ultrasonic datapaths. It consumes single-cycle button pulses and runs the stopwatch run/stop/clear state machine. It also runs a periodic ultrasonic measurement scheduler with a timeout. The shared buttons are routed to whichever function is selected by the current mode.

## Interface
- CLK_HZ, 100_000_000: clock frequency; DIV = CLK_HZ/1000 cycles per ms tick. CLK_HZ must be a multiple of 1000.
- US_PERIOD_MS, 100: interval between successive ultrasonic trigger starts.
- US_TIMEOUT_MS, 30: maximum wait for a measurement result; must be < US_PERIOD_MS.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_btn_run_stop  in  1  debounced one-cycle pulse.
- i_btn_clear  in  1  debounced one-cycle pulse.
- i_btn_run_md  in  1  debounced one-cycle pulse; toggles mode.
- i_us_done  in  1  one-cycle pulse from the ultrasonic receiver: measurement valid.
- o_mode  out  1  0 = stopwatch, 1 = ultrasonic.
- o_sw_run  out  1  level; the stopwatch counter advances while high.
- o_sw_clear  out  1  one-cycle pulse; zeroes the stopwatch counter.
- o_us_start  out  1  one-cycle pulse; launches one trigger/echo measurement.
- o_us_clear  out  1  one-cycle pulse; clears the held distance.
- o_us_timeout  out  1  one-cycle pulse; the measurement got no echo.

## Operation
- Reset values: all outputs 0; stopwatch FSM SW_STOP; ultrasonic FSM US_IDLE; us_en = 0; prescaler and ms counter = 0.
- Mode: i_btn_run_md toggles o_mode.
  - In the same cycle, any run_stop or clear pulse is ignored.
  - Leaving ultrasonic mode forces US_IDLE and us_en = 0.
  - The stopwatch FSM keeps its state across mode changes, so it keeps running in the background.
- Button routing: run_stop and clear act on the stopwatch FSM only when o_mode = 0, and on the ultrasonic logic only when o_mode = 1.
- Stopwatch FSM:
  - SW_STOP: clear goes to SW_CLEAR; otherwise run_stop goes to SW_RUN. Clear wins when both pulse together.
  - SW_RUN: run_stop goes to SW_STOP; clear is ignored.
  - SW_CLEAR: lasts exactly one cycle, then goes to SW_STOP.
  - Outputs: o_sw_run = (state == SW_RUN); o_sw_clear = (state == SW_CLEAR).
- Ultrasonic:
  - run_stop toggles us_en.
  - clear pulses o_us_clear; it does not change FSM state.
  - US_IDLE: us_en = 1 goes to US_TRIG.
  - US_TRIG: o_us_start = 1; prescaler and ms counter are zeroed; next state is US_WAIT.
  - US_WAIT: i_us_done goes to US_HOLD. When elapsed time reaches US_TIMEOUT_MS, pulse o_us_timeout and go to US_HOLD. If done and timeout coincide, done wins and there is no timeout pulse.
  - US_HOLD: when elapsed time reaches US_PERIOD_MS, go to US_TRIG.
  - us_en = 0 in any state returns the FSM to US_IDLE on the next cycle. An in-flight measurement is abandoned with no timeout pulse.
  - i_us_done outside US_WAIT is ignored.
- Elapsed-time counter: an ms counter advanced by the prescaler tick (prescaler wraps at DIV-1). Width is clog2(US_PERIOD_MS+1); no wrap, because the counter is zeroed in each US_TRIG.

## Timing
- All outputs are registered. A button pulse in cycle N produces its output effect in cycle N+1.
- Enabling in US_IDLE with run_stop at cycle N gives o_us_start high at N+1.
- Trigger period: start-to-start is exactly US_PERIOD_MS*DIV cycles.
- Timeout: start-to-timeout is exactly US_TIMEOUT_MS*DIV cycles.
- Asynchronous reset asserted mid-operation returns everything to the reset values immediately. No pulse is emitted on deassertion.

## Structure
- Shared package holds:
  - the state encodings SW_STOP/SW_RUN/SW_CLEAR and US_IDLE/US_TRIG/US_WAIT/US_HOLD (2 bits each);
  - the MODE_SW = 0 / MODE_US = 1 constants.
- One natural sub-module: ms_tick_gen. It is a DIV prescaler with a synchronous clear input and a one-cycle tick output, reused by the datapaths.

## Test plan
All scenarios use CLK_HZ=10_000 (DIV=10), US_PERIOD_MS=5, US_TIMEOUT_MS=3.
1. Stopwatch sequence. Run_stop, wait 5 cycles, run_stop, clear -> o_sw_run high for 5 cycles; o_sw_clear a single pulse one cycle after the clear; o_sw_run ends 0.
2. Simultaneous and ignored pulses. Clear+run_stop together in SW_STOP -> clear pulse only, o_sw_run stays 0. Clear in SW_RUN -> ignored.
3. Periodic triggering. Mode to 1, run_stop, i_us_done 12 cycles after each start -> o_us_start every 50 cycles; o_us_timeout never asserted.
4. Timeout. Mode 1, enabled, no i_us_done -> o_us_timeout exactly 30 cycles after each o_us_start, next start 50 cycles after the previous one. i_us_done in the timeout cycle -> no timeout pulse.
5. Mode interplay. Stopwatch running, switch to mode 1 -> o_sw_run stays 1. Switching back during US_WAIT -> US_IDLE, no further o_us_start. Run_stop in the same cycle as the mode pulse -> ignored.
6. Reset. Assert reset asynchronously during US_WAIT with the stopwatch running -> all outputs 0 without waiting for a clock edge; after release, no activity until a button pulse.
